// File: rtl/wb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_pkg : shared widths, entry type and reset values for the writeback block
// Rev 1.0
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic                 c_WE_RST       = 1'b0;
  localparam logic [WB_ADDR_W-1:0] c_WRITETO_RST  = '0;
  localparam logic [WB_DATA_W-1:0] c_WRITEDAT_RST = '0;
  // Flag means "mem was granted last"; clearing it makes mem win the first tie.
  localparam logic                 c_LAST_MEM_RST = 1'b0;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_fifo : in-order pending-write buffer with per-slot valid bits
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [W-1:0]                  push_data_i,
  input  logic                          pop_i,
  output logic [W-1:0]                  head_data_o,
  output logic [DEPTH-1:0][W-1:0]       slots_o,
  output logic [DEPTH-1:0]              slot_vld_o,
  output logic [$clog2(DEPTH)-1:0]      head_ptr_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [PTR_W-1:0]        rd_q, wr_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    w_full, w_do_push, w_do_pop;

  assign w_full    = (cnt_q == CNT_W'(DEPTH));
  assign w_do_pop  = pop_i && (cnt_q != '0);
  // A full buffer only takes a new entry when the head leaves on the same edge.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_comb begin
    vld_d = vld_q;
    if (w_do_pop)  vld_d[rd_q] = 1'b0;
    if (w_do_push) vld_d[wr_q] = 1'b1;
  end

  assign cnt_d = cnt_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (w_do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_data_o = mem_q[rd_q];
  assign slots_o     = mem_q;
  assign slot_vld_o  = vld_q;
  assign head_ptr_o  = rd_q;
  assign count_o     = cnt_q;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_writeback : round-robin ALU/load arbiter, pending-write buffer,
// register-file write port and read forwarding (built when WB_FORWARD_EN).
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [ADDR_W-1:0]        writeto,
  output logic [DATA_W-1:0]        writedat,
  output logic                     writeenable,
  input  logic [ADDR_W-1:0]        read1,
  input  logic [ADDR_W-1:0]        read2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_W-1:0]        fwd1,
  output logic [DATA_W-1:0]        fwd2,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic                        last_mem_q, last_mem_d;
  logic                        we_q;
  logic [ADDR_W-1:0]           writeto_q;
  logic [DATA_W-1:0]           writedat_q;

  logic                        w_gnt_alu, w_gnt_mem;
  logic                        w_room, w_xfer, w_push, w_pop;
  logic [ENT_W-1:0]            w_push_ent, w_head_ent;
  logic [DEPTH-1:0][ENT_W-1:0] w_slots;
  logic [DEPTH-1:0]            w_slot_vld;
  logic [PTR_W-1:0]            w_head_ptr;
  logic [CNT_W-1:0]            w_count;

  // Tie goes to whichever source did not win last; a lone requester always wins.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_mem = 1'b0;
    if (alu_valid && mem_valid) begin
      w_gnt_mem = ~last_mem_q;
      w_gnt_alu = last_mem_q;
    end else begin
      w_gnt_mem = mem_valid;
      w_gnt_alu = alu_valid;
    end
  end

  assign w_pop      = (w_count != '0);
  assign w_room     = (w_count < CNT_W'(DEPTH)) || w_pop;
  assign alu_ready  = w_gnt_alu && w_room;
  assign mem_ready  = w_gnt_mem && w_room;
  assign w_xfer     = alu_ready || mem_ready;
  assign w_push_ent = w_gnt_mem ? {mem_dest, mem_data} : {alu_dest, alu_data};
  // Writes to r0 complete the handshake but are dropped here.
  assign w_push     = w_xfer && (w_push_ent[ENT_W-1 -: ADDR_W] != '0);
  assign last_mem_d = w_xfer ? w_gnt_mem : last_mem_q;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (w_push),
    .push_data_i (w_push_ent),
    .pop_i       (w_pop),
    .head_data_o (w_head_ent),
    .slots_o     (w_slots),
    .slot_vld_o  (w_slot_vld),
    .head_ptr_o  (w_head_ptr),
    .count_o     (w_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_mem_q <= c_LAST_MEM_RST;
      we_q       <= c_WE_RST;
      writeto_q  <= ADDR_W'(c_WRITETO_RST);
      writedat_q <= DATA_W'(c_WRITEDAT_RST);
    end else begin
      last_mem_q <= last_mem_d;
      we_q       <= w_pop;
      if (w_pop) begin
        writeto_q  <= w_head_ent[ENT_W-1 -: ADDR_W];
        writedat_q <= w_head_ent[DATA_W-1:0];
      end
    end
  end

  assign writeenable = we_q;
  assign writeto     = writeto_q;
  assign writedat    = writedat_q;
  assign pending     = w_count;

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest (output register, then head..tail) so the last match wins.
  always_comb begin : b_fwd
    logic [PTR_W-1:0] idx;
    idx  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    if (we_q && (writeto_q == read1)) begin
      hit1 = 1'b1;
      fwd1 = writedat_q;
    end
    if (we_q && (writeto_q == read2)) begin
      hit2 = 1'b1;
      fwd2 = writedat_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = w_head_ptr + PTR_W'(k);
      if (w_slot_vld[idx] && (w_slots[idx][ENT_W-1 -: ADDR_W] == read1)) begin
        hit1 = 1'b1;
        fwd1 = w_slots[idx][DATA_W-1:0];
      end
      if (w_slot_vld[idx] && (w_slots[idx][ENT_W-1 -: ADDR_W] == read2)) begin
        hit2 = 1'b1;
        fwd2 = w_slots[idx][DATA_W-1:0];
      end
    end
    if (read1 == '0) begin
      hit1 = 1'b0;
      fwd1 = '0;
    end
    if (read2 == '0) begin
      hit2 = 1'b0;
      fwd2 = '0;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{read1, read2, w_slots, w_slot_vld, w_head_ptr};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign fwd1 = '0;
  assign fwd2 = '0;
`endif

endmodule
`default_nettype wire
